// File: rtl/mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) for the EX stage.
// Works on operand magnitudes, retires BITS_PER_CYCLE multiplier bits per cycle and fixes the sign at the end.
module mul_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ID_EX_MULtype,
  input  logic [1:0]      mul_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            mul_finish,
  output logic            mul_busy,
  output logic [XLEN-1:0] mul_result
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_t;

  state_t            state;
  op_t               op_q;
  logic [CNT_W-1:0]  counter;
  logic [2*XLEN-1:0] mcand_sh;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] acc;
  logic              neg;
  logic              done_q;
  logic [XLEN-1:0]   prev_result;

  logic              rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;
  logic [2*XLEN-1:0] partial, acc_next, product;
  logic [XLEN-1:0]   result_sel;

  // MUL and MULHU treat both operands as unsigned; -2^(XLEN-1) negates to itself as an unsigned magnitude.
  assign rs1_signed = (op_t'(mul_op) == OP_MULH) || (op_t'(mul_op) == OP_MULHSU);
  assign rs2_signed = (op_t'(mul_op) == OP_MULH);
  assign rs1_neg    = rs1_signed & rs1_data[XLEN-1];
  assign rs2_neg    = rs2_signed & rs2_data[XLEN-1];
  assign rs1_mag    = rs1_neg ? -rs1_data : rs1_data;
  assign rs2_mag    = rs2_neg ? -rs2_data : rs2_data;

  // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand_sh << j);
    end
  end

  assign acc_next   = acc + partial;
  assign product    = neg ? -acc_next : acc_next;
  assign result_sel = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // A flush in the DONE cycle suppresses the pulse combinationally so the stall logic never sees it.
  assign mul_finish = done_q & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= OP_MUL;
      counter     <= '0;
      mcand_sh    <= '0;
      mplier      <= '0;
      acc         <= '0;
      neg         <= 1'b0;
      done_q      <= 1'b0;
      mul_busy    <= 1'b0;
      mul_result  <= '0;
      prev_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (ID_EX_MULtype != 2'b00 && !flush) begin
            mcand_sh <= {{XLEN{1'b0}}, rs1_mag};
            mplier   <= rs2_mag;
            neg      <= rs1_neg ^ rs2_neg;
            op_q     <= op_t'(mul_op);
            acc      <= '0;
            counter  <= '0;
            mul_busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            mul_busy <= 1'b0;
            counter  <= '0;
            state    <= IDLE;
          end else begin
            acc      <= acc_next;
            mcand_sh <= mcand_sh << BITS_PER_CYCLE;
            mplier   <= mplier >> BITS_PER_CYCLE;
            counter  <= counter + 1'b1;
            if (counter == CNT_W'(N - 1)) begin
              prev_result <= mul_result;
              mul_result  <= result_sel;
              mul_busy    <= 1'b0;
              done_q      <= 1'b1;
              counter     <= '0;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          // A flushed result must not become architecturally visible; restore the previous one.
          if (flush) mul_result <= prev_result;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit: latency, products for all four ops,
// back-to-back issue, bubble, flush abort and mid-operation reset.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mul_type = 2'b00;
  logic [1:0]  mul_op = 2'b00;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        mul_finish;
  logic        mul_busy;
  logic [31:0] mul_result;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

  mul_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID_EX_MULtype(mul_type),
    .mul_op       (mul_op),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .mul_finish   (mul_finish),
    .mul_busy     (mul_busy),
    .mul_result   (mul_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts rising edges until mul_finish is seen; gives up after 40 edges.
  task automatic wait_finish(input int drop_at, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (drop_at != 0 && n == drop_at) mul_type = 2'b00;
      if (mul_finish) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int drop_at);
    int n;
    @(negedge clk);
    mul_type = 2'b01; mul_op = op; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    check({tag, "_busy"}, 32'(mul_busy), 32'd1);
    rs1_data = ~a; rs2_data = ~b;  // operands are ignored once CALC has started
    wait_finish(drop_at, n);
    check({tag, "_lat"}, 32'(n + 1), 32'd17);
    check({tag, "_res"}, mul_result, exp);
    mul_type = 2'b00;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(mul_finish), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;

    #12;
    check("rst_finish", 32'(mul_finish), 32'd0);
    check("rst_busy", 32'(mul_busy), 32'd0);
    check("rst_result", mul_result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul_7x6",        MUL,    32'd7,        32'd6,        32'h0000002A, 0);
    run_op("mul_neg3x5",     MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 0);
    run_op("mulh_min_sq",    MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op("mulhu_max_sq",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op("mulhsu_max",     MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("mulh_neg3x5_bub", MULH,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 4);

    // Back-to-back: second op is presented while the first is in DONE.
    pulses = 0;
    @(negedge clk);
    mul_type = 2'b01; mul_op = MUL; rs1_data = 32'd3; rs2_data = 32'd4;
    wait_finish(0, n);
    if (mul_finish) pulses++;
    check("b2b_a_res", mul_result, 32'h0000000C);
    mul_op = MULHU; rs1_data = 32'h00010000; rs2_data = 32'h00010000;
    @(posedge clk); #1;
    check("b2b_gap", 32'(mul_finish), 32'd0);
    wait_finish(0, n);
    if (mul_finish) pulses++;
    check("b2b_b_lat", 32'(n), 32'd17);
    check("b2b_b_res", mul_result, 32'h00000001);
    mul_type = 2'b00;
    check("b2b_pulses", 32'(pulses), 32'd2);
    @(posedge clk); #1;

    // Flush in the 5th CALC cycle: abort, no pulse, result keeps 0x1.
    @(negedge clk);
    mul_type = 2'b01; mul_op = MUL; rs1_data = 32'd9; rs2_data = 32'd9;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; mul_type = 2'b00;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(mul_busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (mul_finish) pulses++;
    end
    check("flush_pulses", 32'(pulses), 32'd0);
    check("flush_result", mul_result, 32'h00000001);

    // Reset in the 8th CALC cycle clears outputs at once.
    @(negedge clk);
    mul_type = 2'b01; mul_op = MULHU; rs1_data = 32'hDEADBEEF; rs2_data = 32'h12345678;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; mul_type = 2'b00;
    #1;
    check("mrst_busy", 32'(mul_busy), 32'd0);
    check("mrst_finish", 32'(mul_finish), 32'd0);
    check("mrst_result", mul_result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("post_rst_2x2", MUL, 32'd2, 32'd2, 32'h00000004, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
